// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_pkg
// Description : Shared state encoding, line levels and parity helper for the
//               UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

    typedef logic [2:0] tx_state_t;

    localparam tx_state_t IDLE   = 3'd0;
    localparam tx_state_t START  = 3'd1;
    localparam tx_state_t DATA   = 3'd2;
    localparam tx_state_t PARITY = 3'd3;
    localparam tx_state_t STOP   = 3'd4;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Takes the XOR-reduction of the data so the helper is width-agnostic.
    function automatic logic parity_bit(input logic data_xor, input logic par_typ);
        return data_xor ^ (par_typ == PAR_ODD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_baud_cnt.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_baud_cnt
// Description : Per-bit clock counter and data-bit index for the UART
//               transmitter; pulses o_bit_done on the last clock of a bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_baud_cnt #(
    parameter int BIT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_data_phase,
    input  logic [4:0]       i_prescale,
    output logic             o_bit_done,
    output logic [BIT_W-1:0] o_bit_cnt
);

    logic [4:0]       r_edge_cnt;
    logic [BIT_W-1:0] r_bit_cnt;
    logic [4:0]       w_last;

    // Prescale of 0 and 1 both mean one clock per bit.
    assign w_last     = (i_prescale <= 5'd1) ? 5'd0 : i_prescale - 5'd1;
    assign o_bit_done = i_en && (r_edge_cnt == w_last);
    assign o_bit_cnt  = r_bit_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_edge_cnt <= 5'd0;
            r_bit_cnt  <= '0;
        end else if (!i_en) begin
            r_edge_cnt <= 5'd0;
            r_bit_cnt  <= '0;
        end else if (o_bit_done) begin
            r_edge_cnt <= 5'd0;
            r_bit_cnt  <= i_data_phase ? r_bit_cnt + BIT_W'(1) : '0;
        end else begin
            r_edge_cnt <= r_edge_cnt + 5'd1;
            if (!i_data_phase) begin
                r_bit_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : UART transmitter, start/8 data/optional parity/stop, LSB first.
//               Define UART_TX_HOLD_REG_EN to add a one-byte holding register.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] P_DATA,
    input  logic              Data_Valid,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    input  logic [4:0]        Prescale,
    output logic              TX_OUT,
    output logic              Busy,
    output logic              Hold_Full
);

    localparam int               BIT_W    = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    tx_state_t         r_state;
    tx_state_t         w_state_next;
    logic [DATA_W-1:0] r_data;
    logic              r_par_en;
    logic              r_par_bit;
    logic [4:0]        r_prescale;
    logic              r_tx;
    logic              r_busy;

    logic              w_bit_done;
    logic [BIT_W-1:0]  w_bit_cnt;
    logic              w_load;
    logic [DATA_W-1:0] w_load_data;
    logic              w_load_par_en;
    logic              w_load_par_bit;
    logic [4:0]        w_load_prescale;

`ifdef UART_TX_HOLD_REG_EN
    logic              r_hold_full;
    logic [DATA_W-1:0] r_hold_data;
    logic              r_hold_par_en;
    logic              r_hold_par_bit;
    logic [4:0]        r_hold_prescale;
    logic              w_hold_xfer;
    logic              w_hold_load;

    // A held byte starts as soon as the line is free, including straight out of STOP.
    assign w_hold_xfer = r_hold_full && ((r_state == IDLE) || ((r_state == STOP) && w_bit_done));
    assign w_hold_load = Data_Valid && ((r_state != IDLE) || r_hold_full) && (!r_hold_full || w_hold_xfer);
    assign w_load      = w_hold_xfer || (Data_Valid && (r_state == IDLE) && !r_hold_full);

    assign w_load_data     = w_hold_xfer ? r_hold_data     : P_DATA;
    assign w_load_par_en   = w_hold_xfer ? r_hold_par_en   : PAR_EN;
    assign w_load_par_bit  = w_hold_xfer ? r_hold_par_bit  : parity_bit(^P_DATA, PAR_TYP);
    assign w_load_prescale = w_hold_xfer ? r_hold_prescale : Prescale;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hold_full     <= 1'b0;
            r_hold_data     <= '0;
            r_hold_par_en   <= 1'b0;
            r_hold_par_bit  <= 1'b0;
            r_hold_prescale <= 5'd0;
        end else if (w_hold_load) begin
            r_hold_full     <= 1'b1;
            r_hold_data     <= P_DATA;
            r_hold_par_en   <= PAR_EN;
            r_hold_par_bit  <= parity_bit(^P_DATA, PAR_TYP);
            r_hold_prescale <= Prescale;
        end else if (w_hold_xfer) begin
            r_hold_full <= 1'b0;
        end
    end

    assign Hold_Full = r_hold_full;
`else
    assign w_load          = Data_Valid && (r_state == IDLE);
    assign w_load_data     = P_DATA;
    assign w_load_par_en   = PAR_EN;
    assign w_load_par_bit  = parity_bit(^P_DATA, PAR_TYP);
    assign w_load_prescale = Prescale;
    assign Hold_Full       = 1'b0;
`endif

    uart_tx_baud_cnt #(
        .BIT_W (BIT_W)
    ) u_baud_cnt (
        .clk          (CLK),
        .rst          (RST),
        .i_en         (r_state != IDLE),
        .i_data_phase (r_state == DATA),
        .i_prescale   (r_prescale),
        .o_bit_done   (w_bit_done),
        .o_bit_cnt    (w_bit_cnt)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_load) w_state_next = START;
            START:   if (w_bit_done) w_state_next = DATA;
            DATA:    if (w_bit_done && (w_bit_cnt == LAST_BIT))
                         w_state_next = r_par_en ? PARITY : STOP;
            PARITY:  if (w_bit_done) w_state_next = STOP;
            STOP:    if (w_bit_done) w_state_next = w_load ? START : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_data     <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_prescale <= 5'd0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_data     <= w_load_data;
                r_par_en   <= w_load_par_en;
                r_par_bit  <= w_load_par_bit;
                r_prescale <= w_load_prescale;
            end
        end
    end

    // Line and Busy are both registered from the state, so they move together.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_tx   <= LINE_IDLE;
            r_busy <= 1'b0;
        end else begin
            r_busy <= (r_state != IDLE);
            case (r_state)
                START:   r_tx <= START_BIT;
                DATA:    r_tx <= r_data[w_bit_cnt];
                PARITY:  r_tx <= r_par_bit;
                STOP:    r_tx <= STOP_BIT;
                default: r_tx <= LINE_IDLE;
            endcase
        end
    end

    assign TX_OUT = r_tx;
    assign Busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Directed scoreboard bench for uart_tx; decodes the serial line
//               and compares frames, Busy length and idle gaps.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_typ;
    logic [4:0] prescale;
    logic       tx_out;
    logic       busy;
    logic       hold_full;

    typedef struct packed {
        logic [7:0] data;
        logic       par_en;
        logic       par_typ;
        logic [4:0] presc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    uart_tx #(.DATA_W(8)) dut (
        .CLK        (clk),
        .RST        (rst),
        .P_DATA     (p_data),
        .Data_Valid (data_valid),
        .PAR_EN     (par_en),
        .PAR_TYP    (par_typ),
        .Prescale   (prescale),
        .TX_OUT     (tx_out),
        .Busy       (busy),
        .Hold_Full  (hold_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle strobe, then scramble the inputs to prove they were latched.
    task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                        input logic [4:0] ps, input bit expect_it);
        if (expect_it) sb.push_back('{data: d, par_en: pe, par_typ: pt, presc: ps});
        p_data     = d;
        par_en     = pe;
        par_typ    = pt;
        prescale   = ps;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        p_data     = ~d;
        par_en     = ~pe;
        par_typ    = ~pt;
        prescale   = 5'd3;
    endtask

    task automatic rx_frame(input int peff, input int nbits, output logic [10:0] bits,
                            output int busy_cnt, output int wait_cnt, output bit timed_out);
        bits      = '0;
        busy_cnt  = 0;
        wait_cnt  = 0;
        timed_out = 1'b0;
        @(negedge clk);
        while (tx_out !== 1'b0) begin
            wait_cnt++;
            if (wait_cnt > 2000) begin
                timed_out = 1'b1;
                return;
            end
            @(negedge clk);
        end
        for (int i = 0; i < nbits * peff; i++) begin
            if (i > 0) @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if ((i % peff) == (peff / 2)) bits[i / peff] = tx_out;
        end
    endtask

    task automatic check_next_frame(input string tag, input int exp_wait);
        exp_t        e;
        int          peff;
        int          nbits;
        logic [10:0] exp_bits;
        logic [10:0] bits;
        int          busy_cnt;
        int          wait_cnt;
        bit          timed_out;
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() == 0) return;
        e     = sb.pop_front();
        peff  = (e.presc <= 5'd1) ? 1 : int'(e.presc);
        nbits = e.par_en ? 11 : 10;
        exp_bits = '0;
        for (int k = 0; k < 8; k++) exp_bits[1 + k] = e.data[k];
        if (e.par_en) begin
            exp_bits[9]  = (^e.data) ^ e.par_typ;
            exp_bits[10] = 1'b1;
        end else begin
            exp_bits[9] = 1'b1;
        end
        rx_frame(peff, nbits, bits, busy_cnt, wait_cnt, timed_out);
        chk({tag, "_timeout"}, 32'(timed_out), 32'd0);
        if (timed_out) return;
        chk({tag, "_bits"}, 32'(bits), 32'(exp_bits));
        chk({tag, "_busy_len"}, 32'(busy_cnt), 32'(nbits * peff));
        if (exp_wait >= 0) chk({tag, "_gap"}, 32'(wait_cnt), 32'(exp_wait));
    endtask

    task automatic check_idle(input string tag, input int cycles);
        int lows = 0;
        int busys = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (tx_out !== 1'b1) lows++;
            if (busy !== 1'b0) busys++;
        end
        chk({tag, "_line_low"}, 32'(lows), 32'd0);
        chk({tag, "_busy_high"}, 32'(busys), 32'd0);
    endtask

    initial begin
        int w;
        rst        = 1'b1;
        data_valid = 1'b0;
        p_data     = 8'h00;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        prescale   = 5'd8;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_tx", 32'(tx_out), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_hold_full", 32'(hold_full), 32'd0);

        // 0xA5, even / odd parity, then no parity.
        send(8'hA5, 1'b1, 1'b0, 5'd8, 1'b1);
        check_next_frame("a5_even", -1);
        check_idle("a5_even_after", 4);
        send(8'hA5, 1'b1, 1'b1, 5'd8, 1'b1);
        check_next_frame("a5_odd", -1);
        check_idle("a5_odd_after", 4);
        send(8'hA5, 1'b0, 1'b0, 5'd8, 1'b1);
        check_next_frame("a5_nopar", -1);
        check_idle("a5_nopar_after", 4);

        // Loopback-style decode of 0x3C.
        send(8'h3C, 1'b1, 1'b0, 5'd8, 1'b1);
        check_next_frame("loop_3c", -1);
        check_idle("loop_3c_after", 4);

        // Prescale boundaries.
        send(8'h3C, 1'b1, 1'b1, 5'd0, 1'b1);
        check_next_frame("presc0", -1);
        check_idle("presc0_after", 3);
        send(8'hFF, 1'b1, 1'b1, 5'd1, 1'b1);
        check_next_frame("presc1", -1);
        check_idle("presc1_after", 3);
        send(8'h81, 1'b0, 1'b0, 5'd31, 1'b1);
        check_next_frame("presc31", -1);
        check_idle("presc31_after", 3);

        // Reset during DATA bit 3 abandons the frame.
        send(8'hA5, 1'b1, 1'b0, 5'd8, 1'b0);
        w = 0;
        @(negedge clk);
        while ((tx_out !== 1'b0) && (w < 100)) begin
            w++;
            @(negedge clk);
        end
        chk("rst_mid_start_seen", 32'(tx_out), 32'd0);
        repeat (35) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_tx", 32'(tx_out), 32'd1);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        check_idle("rst_mid_after", 16);
        send(8'h3C, 1'b1, 1'b0, 5'd8, 1'b1);
        check_next_frame("post_rst", -1);
        check_idle("post_rst_after", 4);

`ifndef UART_TX_HOLD_REG_EN
        // Strobe mid-frame is ignored.
        send(8'hA5, 1'b1, 1'b0, 5'd8, 1'b1);
        fork
            check_next_frame("ignore_first", -1);
            begin
                repeat (20) @(negedge clk);
                send(8'h11, 1'b0, 1'b0, 5'd8, 1'b0);
                @(negedge clk);
                chk("ignore_hold_full", 32'(hold_full), 32'd0);
            end
        join
        check_idle("ignore_after", 40);
`else
        // Two back-to-back frames via the holding register; third strobe dropped.
        send(8'h55, 1'b0, 1'b0, 5'd8, 1'b1);
        fork
            begin
                check_next_frame("hold_first", -1);
                check_next_frame("hold_second", 0);
            end
            begin
                repeat (20) @(negedge clk);
                send(8'hAA, 1'b0, 1'b0, 5'd8, 1'b1);
                @(negedge clk);
                chk("hold_full_set", 32'(hold_full), 32'd1);
                repeat (5) @(negedge clk);
                send(8'h77, 1'b1, 1'b1, 5'd8, 1'b0);
                @(negedge clk);
                chk("hold_full_kept", 32'(hold_full), 32'd1);
            end
        join
        chk("hold_full_clear", 32'(hold_full), 32'd0);
        check_idle("hold_after", 40);
`endif

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
